// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions: modulus, coefficient type and the
// inline modular add/sub/halve helpers used by the butterfly stages.
package ntt_pkg;

  localparam logic [27:0] Q        = 28'd268369921;
  localparam int          TW_DEPTH = 16;

  typedef logic [27:0] coeff_t;

  function automatic coeff_t mod_add(coeff_t a, coeff_t b);
    logic [28:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) begin
      s = s - {1'b0, Q};
    end
    return s[27:0];
  endfunction

  function automatic coeff_t mod_sub(coeff_t a, coeff_t b);
    logic [28:0] t;
    if (a >= b) begin
      t = {1'b0, a} - {1'b0, b};
    end else begin
      t = {1'b0, a} + {1'b0, Q} - {1'b0, b};
    end
    return t[27:0];
  endfunction

  // Odd values borrow q so the shift is exact; the 29-bit sum cannot overflow.
  function automatic coeff_t mod_half(coeff_t v);
    logic [28:0] t;
    t = v[0] ? ({1'b0, v} + {1'b0, Q}) : {1'b0, v};
    return t[28:1];
  endfunction

endpackage

// File: rtl/inv_butterfly_if.sv
// Beat-in / result-out bundle of one inverse butterfly slot.
interface inv_butterfly_if;
  import ntt_pkg::*;

  logic   in_valid;
  coeff_t x_in;
  coeff_t y_in;
  logic   out_valid;
  coeff_t x_out;
  coeff_t y_out;

  modport master (
    output in_valid, x_in, y_in,
    input  out_valid, x_out, y_out
  );

  modport slave (
    input  in_valid, x_in, y_in,
    output out_valid, x_out, y_out
  );

endinterface

// File: rtl/inv_mod_mult.sv
// Fully pipelined 28x28 modular multiplier, latency LAT (>= 2): one product
// stage, one Solinas reduction stage, then a plain delay line.
module inv_mod_mult
  import ntt_pkg::*;
#(
  parameter int unsigned LAT = 5
) (
  input  logic   clk,
  input  logic   rst,
  input  coeff_t a,
  input  coeff_t b,
  output coeff_t p
);

  logic [55:0] prod_d, prod_q;
  coeff_t      red_d [LAT-1];
  coeff_t      red_q [LAT-1];

  // 2^28 == 2^16 - 1 (mod q): fold the high part three times, then one subtract.
  function automatic coeff_t fold(logic [55:0] v);
    logic [44:0] f1;
    logic [33:0] f2;
    logic [28:0] f3;
    f1 = {1'b0, v[55:28], 16'b0} - 45'(v[55:28]) + 45'(v[27:0]);
    f2 = {1'b0, f1[44:28], 16'b0} - 34'(f1[44:28]) + 34'(f1[27:0]);
    f3 = 29'({f2[33:28], 16'b0}) - 29'(f2[33:28]) + 29'(f2[27:0]);
    if (f3 >= 29'(Q)) begin
      f3 = f3 - 29'(Q);
    end
    return f3[27:0];
  endfunction

  always_comb begin
    prod_d   = 56'(a) * 56'(b);
    red_d[0] = fold(prod_q);
    for (int unsigned i = 1; i < LAT - 1; i++) begin
      red_d[i] = red_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      red_q  <= '{default: '0};
    end else begin
      prod_q <= prod_d;
      red_q  <= red_d;
    end
  end

  assign p = red_q[LAT-2];

endmodule

// File: rtl/inv_butterfly.sv
// Gentleman-Sande inverse-NTT butterfly: x' = x + y, y' = (x - y) * w mod q,
// optionally halved, with a per-instance twiddle schedule.
module inv_butterfly
  import ntt_pkg::*;
#(
  parameter int unsigned                  START    = 0,
  parameter coeff_t [TW_DEPTH-1:0]        FACTORS  = {TW_DEPTH{28'd1}},
  parameter bit                           HALVE    = 1'b0,
  parameter int unsigned                  MULT_LAT = 5
) (
  input  logic          clk,
  input  logic          rst,
  inv_butterfly_if.slave bus
);

  localparam logic [7:0] START_C = 8'(START);

  logic [7:0]          pre_d, pre_q;
  logic [3:0]          idx_d, idx_q;
  coeff_t              s_d, s_q;
  coeff_t              d_d, d_q;
  coeff_t              w_d, w_q;
  coeff_t              sdly_d [MULT_LAT];
  coeff_t              sdly_q [MULT_LAT];
  logic [MULT_LAT+1:0] vld_d, vld_q;
  coeff_t              x_out_d, x_out_q;
  coeff_t              y_out_d, y_out_q;
  coeff_t              prod;
  logic                pre_start;

  inv_mod_mult #(
    .LAT (MULT_LAT)
  ) u_mult (
    .clk (clk),
    .rst (rst),
    .a   (d_q),
    .b   (w_q),
    .p   (prod)
  );

  always_comb begin
    pre_start = (pre_q < START_C);
    pre_d     = pre_q;
    idx_d     = idx_q;
    // The pre-start count freezes at START; only then does the index move.
    if (bus.in_valid) begin
      if (pre_start) begin
        pre_d = pre_q + 8'd1;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end

    s_d = mod_add(bus.x_in, bus.y_in);
    d_d = mod_sub(bus.x_in, bus.y_in);
    w_d = pre_start ? FACTORS[0] : FACTORS[idx_q];

    sdly_d[0] = s_q;
    for (int unsigned i = 1; i < MULT_LAT; i++) begin
      sdly_d[i] = sdly_q[i-1];
    end

    vld_d = {vld_q[MULT_LAT:0], bus.in_valid};

    x_out_d = HALVE ? mod_half(sdly_q[MULT_LAT-1]) : sdly_q[MULT_LAT-1];
    y_out_d = HALVE ? mod_half(prod) : prod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      idx_q   <= '0;
      s_q     <= '0;
      d_q     <= '0;
      w_q     <= '0;
      sdly_q  <= '{default: '0};
      vld_q   <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      d_q     <= d_d;
      w_q     <= w_d;
      sdly_q  <= sdly_d;
      vld_q   <= vld_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
    end
  end

  assign bus.out_valid = vld_q[MULT_LAT+1];
  assign bus.x_out     = x_out_q;
  assign bus.y_out     = y_out_q;

endmodule

// File: tb/tb_inv_butterfly.sv
// Self-checking bench for inv_butterfly: five parameterised instances share
// one stimulus bus; expected results go through a single in-order scoreboard.
module tb_inv_butterfly;
  import ntt_pkg::*;

  localparam int NDUT    = 5;
  localparam int LATENCY = 7;

  typedef coeff_t [TW_DEPTH-1:0] tw_tbl_t;

  function automatic tw_tbl_t mk_seq();
    tw_tbl_t f;
    for (int i = 0; i < TW_DEPTH; i++) f[i] = coeff_t'(i + 1);
    return f;
  endfunction

  function automatic tw_tbl_t mk_big();
    tw_tbl_t f;
    for (int i = 0; i < TW_DEPTH; i++) f[i] = Q - 28'd1 - coeff_t'(i * 16777259);
    return f;
  endfunction

  localparam tw_tbl_t F_SEQ = mk_seq();
  localparam tw_tbl_t F_BIG = mk_big();

  typedef struct {
    int     sel;
    coeff_t ex;
    coeff_t ey;
    int     cyc;
  } exp_t;

  typedef struct {
    int     sel;
    coeff_t x;
    coeff_t y;
    coeff_t ex;
    coeff_t ey;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   in_valid = 1'b0;
  int     sel = 0;
  coeff_t x = '0;
  coeff_t y = '0;
  int     cyc = 0;
  bit     armed = 1'b0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     kc [NDUT];
  exp_t   sbq [$];
  vec_t   vt [10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_butterfly_if if0 ();
  inv_butterfly_if if1 ();
  inv_butterfly_if if2 ();
  inv_butterfly_if if3 ();
  inv_butterfly_if if4 ();

  assign if0.in_valid = in_valid && (sel == 0);
  assign if1.in_valid = in_valid && (sel == 1);
  assign if2.in_valid = in_valid && (sel == 2);
  assign if3.in_valid = in_valid && (sel == 3);
  assign if4.in_valid = in_valid && (sel == 4);
  assign if0.x_in = x;  assign if0.y_in = y;
  assign if1.x_in = x;  assign if1.y_in = y;
  assign if2.x_in = x;  assign if2.y_in = y;
  assign if3.x_in = x;  assign if3.y_in = y;
  assign if4.x_in = x;  assign if4.y_in = y;

  inv_butterfly u0 (.clk(clk), .rst(rst), .bus(if0));
  inv_butterfly #(.FACTORS({TW_DEPTH{28'd2}})) u1 (.clk(clk), .rst(rst), .bus(if1));
  inv_butterfly #(.HALVE(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));
  inv_butterfly #(.START(2), .FACTORS(F_SEQ)) u3 (.clk(clk), .rst(rst), .bus(if3));
  inv_butterfly #(.FACTORS(F_BIG)) u4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic coeff_t ref_w(int s, int k);
    case (s)
      1:       return 28'd2;
      3:       return (k < 2) ? 28'd1 : F_SEQ[(k - 2) % TW_DEPTH];
      4:       return F_BIG[k % TW_DEPTH];
      default: return 28'd1;
    endcase
  endfunction

  function automatic coeff_t ref_half(longint unsigned v);
    longint unsigned ql = longint'(Q);
    return coeff_t'((v % 2 == 1) ? (v + ql) / 2 : v / 2);
  endfunction

  task automatic ref_out(input int s, input coeff_t xv, input coeff_t yv,
                         output coeff_t xo, output coeff_t yo);
    longint unsigned ql = longint'(Q);
    longint unsigned sv = (longint'(xv) + longint'(yv)) % ql;
    longint unsigned dv = (longint'(xv) + ql - longint'(yv)) % ql;
    longint unsigned pv = (dv * longint'(ref_w(s, kc[s]))) % ql;
    if (s == 2) begin
      xo = ref_half(sv);
      yo = ref_half(pv);
    end else begin
      xo = coeff_t'(sv);
      yo = coeff_t'(pv);
    end
  endtask

  task automatic beat(input int s, input coeff_t xv, input coeff_t yv,
                      input coeff_t ex, input coeff_t ey);
    exp_t e;
    @(posedge clk); #1;
    sel = s; in_valid = 1'b1; x = xv; y = yv;
    e.sel = s; e.ex = ex; e.ey = ey; e.cyc = cyc;
    sbq.push_back(e);
    kc[s]++;
  endtask

  task automatic beat_m(input int s, input coeff_t xv, input coeff_t yv);
    coeff_t ex, ey;
    ref_out(s, xv, yv, ex, ey);
    beat(s, xv, yv, ex, ey);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
    check("drain_pending", sbq.size(), 0);
    idle(2);
  endtask

  // Beats captured before this reset are discarded; in_valid stays high to prove it is ignored.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; sel = 3; x = 28'd1; y = 28'd0;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < NDUT; i++) kc[i] = 0;
    @(negedge clk);
    check("rst_out_valid", if3.out_valid, 0);
  endtask

  task automatic chk_port(input int s, input logic ov, input coeff_t xo, input coeff_t yo);
    exp_t e;
    check("no_x", $isunknown({ov, xo, yo}), 0);
    if (ov === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_out_valid", s, -1);
      end else begin
        e = sbq.pop_front();
        check("out_port", s, e.sel);
        check("latency", cyc - e.cyc, LATENCY);
        check("x_out", xo, e.ex);
        check("y_out", yo, e.ey);
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk_port(0, if0.out_valid, if0.x_out, if0.y_out);
      chk_port(1, if1.out_valid, if1.x_out, if1.y_out);
      chk_port(2, if2.out_valid, if2.x_out, if2.y_out);
      chk_port(3, if3.out_valid, if3.x_out, if3.y_out);
      chk_port(4, if4.out_valid, if4.x_out, if4.y_out);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{0, 28'd5,         28'd3,         28'd8,         28'd2};
    vt[1] = '{1, 28'd268369920, 28'd2,         28'd1,         28'd268369915};
    vt[2] = '{1, 28'd3,         28'd5,         28'd8,         28'd268369917};
    vt[3] = '{2, 28'd4,         28'd1,         28'd134184963, 28'd134184962};
    vt[4] = '{2, 28'd6,         28'd2,         28'd4,         28'd2};
    vt[5] = '{0, 28'd7,         28'd7,         28'd14,        28'd0};
    vt[6] = '{0, 28'd268369920, 28'd268369920, 28'd268369919, 28'd0};
    vt[7] = '{0, 28'd0,         28'd1,         28'd1,         28'd268369920};
    vt[8] = '{1, 28'd134184961, 28'd134184960, 28'd0,         28'd2};
    vt[9] = '{2, 28'd268369920, 28'd0,         28'd134184960, 28'd134184960};
    for (int i = 0; i < NDUT; i++) kc[i] = 0;

    // Reset with a live beat on the bus: nothing may enter.
    rst = 1'b1; in_valid = 1'b1; sel = 0; x = 28'd5; y = 28'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid_0", if0.out_valid, 0); check("reset_x_0", if0.x_out, 0); check("reset_y_0", if0.y_out, 0);
    check("reset_valid_1", if1.out_valid, 0); check("reset_x_1", if1.x_out, 0); check("reset_y_1", if1.y_out, 0);
    check("reset_valid_2", if2.out_valid, 0); check("reset_x_2", if2.x_out, 0); check("reset_y_2", if2.y_out, 0);
    check("reset_valid_3", if3.out_valid, 0); check("reset_x_3", if3.x_out, 0); check("reset_y_3", if3.y_out, 0);
    check("reset_valid_4", if4.out_valid, 0); check("reset_x_4", if4.x_out, 0); check("reset_y_4", if4.y_out, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; armed = 1'b1;

    // Single isolated beat, then the whole table back-to-back.
    beat(vt[0].sel, vt[0].x, vt[0].y, vt[0].ex, vt[0].ey);
    idle(1);
    drain();
    for (int i = 0; i < 10; i++) beat(vt[i].sel, vt[i].x, vt[i].y, vt[i].ex, vt[i].ey);
    idle(1);
    drain();

    // Twiddle schedule: y_out = w for x=1, y=0 -> 1,1,1,2..16,1,2.
    for (int i = 0; i < 20; i++) beat_m(3, 28'd1, 28'd0);
    idle(1);
    drain();

    // Same schedule with a bubble after every beat.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      beat_m(3, 28'd1, 28'd0);
      idle(1);
    end
    drain();

    // Reset after five accepted beats; the restart begins again at k=0.
    do_reset();
    for (int i = 0; i < 5; i++) beat_m(3, 28'd1, 28'd0);
    do_reset();
    for (int i = 0; i < 20; i++) beat_m(3, 28'd1, 28'd0);
    idle(1);
    drain();

    // Random operands on the full-width twiddle instance and the scheduled one.
    for (int i = 0; i < 40; i++) begin
      beat_m((i % 2 == 1) ? 4 : 3, coeff_t'($urandom_range(268369920, 0)),
             coeff_t'($urandom_range(268369920, 0)));
      if ($urandom_range(3, 0) == 0) idle(1);
    end
    idle(1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
